// File: rtl/pipe_stage_reg_if.sv
// Signal bundle between a pipeline stage and its inter-stage register.
// The upstream side drives the *_i fields and reads back the registered *_o fields.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int A_W    = 5,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [PC_W-1:0]   pc_i;
  logic [DATA_W-1:0] data_i;
  logic [A_W-1:0]    a2_i;
  logic [A_W-1:0]    a3_i;
  logic              reg_we_i;
  logic              mem_we_i;
  logic [TNEW_W-1:0] tnew_i;

  logic              valid_o;
  logic [PC_W-1:0]   pc_o;
  logic [DATA_W-1:0] data_o;
  logic [A_W-1:0]    a2_o;
  logic [A_W-1:0]    a3_o;
  logic              reg_we_o;
  logic              mem_we_o;
  logic [TNEW_W-1:0] tnew_o;
  logic              fwd_ready_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, pc_i, data_i, a2_i, a3_i, reg_we_i, mem_we_i, tnew_i,
    input  valid_o, pc_o, data_o, a2_o, a3_o, reg_we_o, mem_we_o, tnew_o, fwd_ready_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, pc_i, data_i, a2_i, a3_i, reg_we_i, mem_we_i, tnew_i,
    output valid_o, pc_o, data_o, a2_o, a3_o, reg_we_o, mem_we_o, tnew_o, fwd_ready_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, bubble insertion, a Tnew countdown that
// keeps maturing while held, a registered forwarding-ready flag and a bubble counter.
module pipe_stage_reg #(
  parameter int DATA_W           = 32,
  parameter int PC_W             = 32,
  parameter int A_W              = 5,
  parameter int TNEW_W           = 2,
  parameter bit KEEP_PC_ON_FLUSH = 1'b1,
  parameter int CNT_W            = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipe_stage_reg_if.slave bus
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STALL = 2'd1,
    OP_FLUSH = 2'd2
  } op_e;

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    logic [TNEW_W-1:0] r;
    if (x == {TNEW_W{1'b0}}) begin
      r = {TNEW_W{1'b0}};
    end else begin
      r = x - TNEW_W'(1);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    logic [CNT_W-1:0] r;
    if (x == {CNT_W{1'b1}}) begin
      r = x;
    end else begin
      r = x + CNT_W'(1);
    end
    return r;
  endfunction

  op_e               op_s;
  logic              bubble_s;

  logic              valid_r,      valid_s;
  logic [PC_W-1:0]   pc_r,         pc_s;
  logic [DATA_W-1:0] data_r,       data_s;
  logic [A_W-1:0]    a2_r,         a2_s;
  logic [A_W-1:0]    a3_r,         a3_s;
  logic              reg_we_r,     reg_we_s;
  logic              mem_we_r,     mem_we_s;
  logic [TNEW_W-1:0] tnew_r,       tnew_s;
  logic              fwd_ready_r,  fwd_ready_s;
  logic [CNT_W-1:0]  bubble_cnt_r, bubble_cnt_s;

  // Operation select: flush wins over stall, stall wins over load.
  always_comb begin
    op_s = OP_LOAD;
    if (bus.flush_i) begin
      op_s = OP_FLUSH;
    end else if (bus.stall_i) begin
      op_s = OP_STALL;
    end else begin
      op_s = OP_LOAD;
    end
  end

  // Next-state computation for every stored field.
  always_comb begin
    valid_s  = valid_r;
    pc_s     = pc_r;
    data_s   = data_r;
    a2_s     = a2_r;
    a3_s     = a3_r;
    reg_we_s = reg_we_r;
    mem_we_s = mem_we_r;
    tnew_s   = tnew_r;
    bubble_s = 1'b0;

    case (op_s)
      OP_FLUSH: begin
        valid_s  = 1'b0;
        data_s   = {DATA_W{1'b0}};
        a2_s     = {A_W{1'b0}};
        a3_s     = {A_W{1'b0}};
        reg_we_s = 1'b0;
        mem_we_s = 1'b0;
        tnew_s   = {TNEW_W{1'b0}};
        bubble_s = 1'b1;
        if (KEEP_PC_ON_FLUSH) begin
          pc_s = bus.pc_i;
        end else begin
          pc_s = {PC_W{1'b0}};
        end
      end
      OP_STALL: begin
        // A held result keeps counting down toward availability.
        tnew_s = sat_dec(tnew_r);
      end
      OP_LOAD: begin
        valid_s  = bus.valid_i;
        pc_s     = bus.pc_i;
        data_s   = bus.data_i;
        a2_s     = bus.a2_i;
        a3_s     = bus.a3_i;
        reg_we_s = bus.reg_we_i & bus.valid_i;
        mem_we_s = bus.mem_we_i & bus.valid_i;
        tnew_s   = sat_dec(bus.tnew_i);
        bubble_s = ~bus.valid_i;
      end
      default: begin
        valid_s  = valid_r;
        tnew_s   = tnew_r;
        bubble_s = 1'b0;
      end
    endcase
  end

  // Forwarding flag and bubble count derived from the next-state fields so both register cleanly.
  always_comb begin
    fwd_ready_s = valid_s & reg_we_s & (a3_s != {A_W{1'b0}}) & (tnew_s == {TNEW_W{1'b0}});
    if (bubble_s) begin
      bubble_cnt_s = sat_inc(bubble_cnt_r);
    end else begin
      bubble_cnt_s = bubble_cnt_r;
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r      <= 1'b0;
      pc_r         <= {PC_W{1'b0}};
      data_r       <= {DATA_W{1'b0}};
      a2_r         <= {A_W{1'b0}};
      a3_r         <= {A_W{1'b0}};
      reg_we_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      tnew_r       <= {TNEW_W{1'b0}};
      fwd_ready_r  <= 1'b0;
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      valid_r      <= valid_s;
      pc_r         <= pc_s;
      data_r       <= data_s;
      a2_r         <= a2_s;
      a3_r         <= a3_s;
      reg_we_r     <= reg_we_s;
      mem_we_r     <= mem_we_s;
      tnew_r       <= tnew_s;
      fwd_ready_r  <= fwd_ready_s;
      bubble_cnt_r <= bubble_cnt_s;
    end
  end

  assign bus.valid_o      = valid_r;
  assign bus.pc_o         = pc_r;
  assign bus.data_o       = data_r;
  assign bus.a2_o         = a2_r;
  assign bus.a3_o         = a3_r;
  assign bus.reg_we_o     = reg_we_r;
  assign bus.mem_we_o     = mem_we_r;
  assign bus.tnew_o       = tnew_r;
  assign bus.fwd_ready_o  = fwd_ready_r;
  assign bus.bubble_cnt_o = bubble_cnt_r;

endmodule
